// File: rtl/lane_packer_if.sv
// Lane-side (FIFO pop) and word-side (valid/ready) signals of lane_packer.
// The master modport is the packer's view; slave is the surrounding environment.
interface lane_packer_if #(
    parameter int M          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_BYTES  = 8
);
    logic [0:M-1][DATA_WIDTH-1:0]         data_i;
    logic [0:M-1]                         fifo_empty_i;
    logic [0:M-1]                         rd_en_o;
    logic                                 flush_i;
    logic                                 valid_o;
    logic                                 ready_i;
    logic [OUT_BYTES-1:0][DATA_WIDTH-1:0] data_o;
    logic [OUT_BYTES-1:0]                 keep_o;
    logic                                 last_o;

    modport master (
        input  data_i, fifo_empty_i, flush_i, ready_i,
        output rd_en_o, valid_o, data_o, keep_o, last_o
    );

    modport slave (
        output data_i, fifo_empty_i, flush_i, ready_i,
        input  rd_en_o, valid_o, data_o, keep_o, last_o
    );
endinterface

// File: rtl/lane_packer.sv
// Pops 0..M bytes per cycle from FWFT lanes and packs them into OUT_BYTES-wide
// words, emitting partial words on flush request or idle timeout.
module lane_packer #(
    parameter int M          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_BYTES  = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    lane_packer_if.master bus
);
    localparam int            CW   = $clog2(OUT_BYTES + 1);
    localparam int            TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] FULL = CW'(OUT_BYTES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [OUT_BYTES-1:0][DATA_WIDTH-1:0] r_acc;
    logic [OUT_BYTES-1:0][DATA_WIDTH-1:0] r_data;
    logic [OUT_BYTES-1:0]                 r_keep;
    logic [CW-1:0]                        r_cnt;
    logic [TW-1:0]                        r_idle;
    logic                                 r_flush_pend;
    logic                                 r_valid;
    logic                                 r_last;

    logic [OUT_BYTES-1:0][DATA_WIDTH-1:0] w_acc_nxt;
    logic [OUT_BYTES-1:0][DATA_WIDTH-1:0] w_word;
    logic [OUT_BYTES-1:0]                 w_keep;
    logic [0:M-1]                         w_rd_en;
    logic [CW-1:0]                        w_lead;
    logic [CW-1:0]                        w_free;
    logic [CW-1:0]                        w_k;
    logic [CW-1:0]                        w_base;
    logic                                 w_slot_free;
    logic                                 w_timeout_hit;
    logic                                 w_xfer;
    logic                                 w_pop;

    assign w_slot_free   = !r_valid || bus.ready_i;
    assign w_timeout_hit = (TIMEOUT != 0) && (r_idle == TMAX);
    assign w_xfer        = w_slot_free &&
                           ((r_cnt == FULL) ||
                            ((r_flush_pend || w_timeout_hit) && (r_cnt != '0)));

    // Leading run of non-empty lanes; a hole stops the run so order is preserved.
    always_comb begin
        logic run;
        w_lead = '0;
        run    = 1'b1;
        for (int unsigned j = 0; j < M; j++) begin
            if (run && !bus.fifo_empty_i[j]) w_lead = w_lead + CW'(1);
            else                             run    = 1'b0;
        end
    end

    always_comb begin
        if (r_flush_pend && !w_xfer) w_free = '0;
        else if (w_xfer)             w_free = FULL;
        else                         w_free = FULL - r_cnt;
        w_k    = (w_lead < w_free) ? w_lead : w_free;
        w_base = w_xfer ? '0 : r_cnt;
        w_pop  = (w_k != '0);
        for (int unsigned j = 0; j < M; j++) begin
            w_rd_en[j] = !rst_i && (CW'(j) < w_k);
        end
    end

    // Popping during a transfer refills from slot 0 while the old acc is captured.
    always_comb begin
        w_acc_nxt = r_acc;
        for (int unsigned i = 0; i < OUT_BYTES; i++) begin
            for (int unsigned j = 0; j < M; j++) begin
                if ((CW'(j) < w_k) && ((w_base + CW'(j)) == CW'(i))) begin
                    w_acc_nxt[i] = bus.data_i[j];
                end
            end
        end
        for (int unsigned i = 0; i < OUT_BYTES; i++) begin
            w_keep[i] = (CW'(i) < r_cnt);
            w_word[i] = w_keep[i] ? r_acc[i] : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_idle       <= '0;
            r_flush_pend <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_keep       <= '0;
            r_last       <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_base + w_k;

            if (w_xfer) begin
                r_data  <= w_word;
                r_keep  <= w_keep;
                r_last  <= r_flush_pend;
                r_valid <= 1'b1;
            end else if (bus.ready_i) begin
                r_valid <= 1'b0;
            end

            if (r_flush_pend) begin
                if (w_xfer || (r_cnt == '0)) r_flush_pend <= 1'b0;
            end else if (bus.flush_i) begin
                r_flush_pend <= 1'b1;
            end

            if (w_pop || (r_cnt == '0)) begin
                r_idle <= '0;
            end else if ((r_cnt != FULL) && (r_idle != TMAX)) begin
                r_idle <= r_idle + TW'(1);
            end
        end
    end

    assign bus.rd_en_o = w_rd_en;
    assign bus.valid_o = r_valid;
    assign bus.data_o  = r_data;
    assign bus.keep_o  = r_keep;
    assign bus.last_o  = r_last;
endmodule

// File: tb/tb_lane_packer.sv
// Directed and random stimulus for lane_packer, checked against an in-order
// byte scoreboard plus explicit latency/keep/last expectations.
module tb_lane_packer;
    localparam int M  = 4;
    localparam int DW = 8;
    localparam int OB = 8;
    localparam int TO = 16;

    logic clk;
    logic rst;

    lane_packer_if #(.M(M), .DATA_WIDTH(DW), .OUT_BYTES(OB)) bus ();

    lane_packer #(.M(M), .DATA_WIDTH(DW), .OUT_BYTES(OB), .TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [7:0]   src[$];
    logic [7:0]   sb[$];
    int           lanes_avail = 0;
    bit           sparse      = 1'b0;
    logic [0:M-1] rd_seen;
    logic [7:0]   bp[24];
    logic [63:0]  held;
    logic [63:0]  expw;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:M-1] lane_prefix(input int n);
        logic [0:M-1] p;
        for (int j = 0; j < M; j++) p[j] = (j < n);
        return p;
    endfunction

    function automatic logic [OB-1:0] keep_prefix(input int n);
        logic [OB-1:0] p;
        for (int i = 0; i < OB; i++) p[i] = (i < n);
        return p;
    endfunction

    function automatic logic [63:0] kept_data();
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < OB; i++) if (bus.keep_o[i]) m[i*8 +: 8] = 8'hFF;
        return bus.data_o & m;
    endfunction

    task automatic present();
        for (int j = 0; j < M; j++) begin
            if (j < lanes_avail && j < int'(src.size()) && !(sparse && j == 1)) begin
                bus.fifo_empty_i[j] = 1'b0;
                bus.data_i[j]       = src[j];
            end else begin
                bus.fifo_empty_i[j] = 1'b1;
                bus.data_i[j]       = 8'h00;
            end
        end
    endtask

    task automatic check_word();
        int kc;
        kc = 0;
        for (int i = 0; i < OB; i++) if (bus.keep_o[i]) kc++;
        check("keep_prefix", bus.keep_o, keep_prefix(kc));
        check("keep_nonempty", kc > 0, 1);
        check("sb_depth", int'(sb.size()) >= kc, 1);
        for (int i = 0; i < kc && sb.size() > 0; i++) begin
            check("word_byte", bus.data_o[i], sb.pop_front());
        end
    endtask

    // One clock: present lanes, sample at negedge, return at posedge+1.
    task automatic tick(input bit flush);
        int n;
        int lead;
        present();
        bus.flush_i = flush;
        @(negedge clk);
        rd_seen = bus.rd_en_o;
        n = 0;
        for (int j = 0; j < M; j++) if (rd_seen[j]) n++;
        lead = 0;
        for (int j = 0; j < M; j++) if (!bus.fifo_empty_i[j] && lead == j) lead++;
        check("rd_en_prefix", rd_seen, lane_prefix(n));
        check("rd_en_bound", n <= lead, 1);
        for (int j = 0; j < n && j < int'(src.size()); j++) sb.push_back(src[j]);
        if (bus.valid_o && bus.ready_i) check_word();
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        repeat (n) if (src.size() > 0) void'(src.pop_front());
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        src.delete();
        lanes_avail = 0;
        bus.ready_i = 1'b1;
        while ((sb.size() != 0 || bus.valid_o) && guard < 80) begin
            tick(1'b0);
            guard++;
        end
        check("drain_done", (sb.size() == 0) && !bus.valid_o, 1);
    endtask

    initial begin
        rst              = 1'b1;
        bus.flush_i      = 1'b0;
        bus.ready_i      = 1'b1;
        bus.data_i       = '0;
        bus.fifo_empty_i = '1;

        // Reset state with all lanes offering data
        for (int i = 0; i < 4; i++) src.push_back(8'($urandom));
        lanes_avail = 4;
        @(posedge clk);
        #1;
        present();
        #1;
        check("rst_valid", bus.valid_o, 0);
        check("rst_keep", bus.keep_o, 0);
        check("rst_data", bus.data_o, 0);
        check("rst_last", bus.last_o, 0);
        check("rst_rd_en", bus.rd_en_o, 0);
        src.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming 0x00..0x0F
        for (int i = 0; i < 16; i++) src.push_back(8'(i));
        lanes_avail = 4;
        bus.ready_i = 1'b1;
        tick(0); tick(0);
        check("stream_latency", bus.valid_o, 0);
        tick(0);
        check("stream_w1_valid", bus.valid_o, 1);
        check("stream_w1_data", bus.data_o, 64'h0706050403020100);
        check("stream_w1_keep", bus.keep_o, 8'hFF);
        check("stream_w1_last", bus.last_o, 0);
        tick(0);
        check("stream_gap", bus.valid_o, 0);
        tick(0);
        check("stream_w2_valid", bus.valid_o, 1);
        check("stream_w2_data", bus.data_o, 64'h0F0E0D0C0B0A0908);
        check("stream_w2_keep", bus.keep_o, 8'hFF);
        drain();

        // Sparse lanes: lane 1 empty blocks lanes 2 and 3
        for (int i = 0; i < 8; i++) src.push_back(8'($urandom));
        lanes_avail = 4;
        sparse      = 1'b1;
        tick(0);
        check("sparse_rd_en_a", rd_seen, lane_prefix(1));
        tick(0);
        check("sparse_rd_en_b", rd_seen, lane_prefix(1));
        sparse = 1'b0;
        drain();

        // Backpressure with more data offered than fits
        for (int i = 0; i < 24; i++) begin
            bp[i] = 8'($urandom);
            src.push_back(bp[i]);
        end
        lanes_avail = 4;
        bus.ready_i = 1'b0;
        repeat (4) tick(0);
        for (int i = 0; i < 8; i++) expw[i*8 +: 8] = bp[i];
        check("bp_w1_valid", bus.valid_o, 1);
        check("bp_w1_data", bus.data_o, expw);
        held = bus.data_o;
        repeat (3) begin
            tick(0);
            check("bp_rd_en_zero", rd_seen, 0);
            check("bp_hold", bus.data_o, held);
            check("bp_hold_valid", bus.valid_o, 1);
        end
        bus.ready_i = 1'b1;
        tick(0);
        for (int i = 0; i < 8; i++) expw[i*8 +: 8] = bp[8 + i];
        check("bp_w2_valid", bus.valid_o, 1);
        check("bp_w2_data", bus.data_o, expw);
        drain();

        // Idle timeout on a 3-byte partial word
        src.push_back(8'hA0); src.push_back(8'hA1); src.push_back(8'hA2);
        lanes_avail = 4;
        tick(0);
        repeat (16) tick(0);
        check("to_not_early", bus.valid_o, 0);
        tick(0);
        check("to_valid", bus.valid_o, 1);
        check("to_keep", bus.keep_o, 8'h07);
        check("to_data", kept_data(), 64'h0000000000A2A1A0);
        check("to_last", bus.last_o, 0);
        drain();

        // Flush of a 5-byte partial word
        for (int i = 0; i < 5; i++) src.push_back(8'(8'h50 + i));
        lanes_avail = 4;
        tick(0); tick(0);
        tick(1);
        check("flush_latency", bus.valid_o, 0);
        tick(0);
        check("flush_valid", bus.valid_o, 1);
        check("flush_keep", bus.keep_o, 8'h1F);
        check("flush_last", bus.last_o, 1);
        check("flush_data", kept_data(), 64'h0000005453525150);
        drain();

        // Flush with nothing accumulated must not emit nor block later pops
        tick(1);
        repeat (3) begin
            tick(0);
            check("flush_empty_novalid", bus.valid_o, 0);
        end
        src.push_back(8'($urandom)); src.push_back(8'($urandom));
        lanes_avail = 4;
        tick(0);
        check("flush_empty_cleared", rd_seen, lane_prefix(2));
        drain();

        // Reset mid-stream while a word is held
        for (int i = 0; i < 16; i++) src.push_back(8'($urandom));
        lanes_avail = 4;
        bus.ready_i = 1'b0;
        repeat (3) tick(0);
        check("pre_rst_valid", bus.valid_o, 1);
        rst = 1'b1;
        #1;
        present();
        #1;
        check("mid_rst_valid", bus.valid_o, 0);
        check("mid_rst_keep", bus.keep_o, 0);
        check("mid_rst_data", bus.data_o, 0);
        check("mid_rst_last", bus.last_o, 0);
        check("mid_rst_rd_en", bus.rd_en_o, 0);
        sb.delete();
        src.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) src.push_back(8'(8'hC0 + i));
        bus.ready_i = 1'b1;
        repeat (3) tick(0);
        check("post_rst_valid", bus.valid_o, 1);
        check("post_rst_data", bus.data_o, 64'hC7C6C5C4C3C2C1C0);
        drain();

        // Random traffic, backpressure and flushes
        for (int c = 0; c < 400; c++) begin
            while (src.size() < 8) src.push_back(8'($urandom));
            lanes_avail = int'($urandom_range(0, M));
            bus.ready_i = ($urandom % 4) != 0;
            tick(($urandom % 20) == 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
